// File: rtl/lc3_pkg.sv
// Shared constants for the LC3 MAR/MDR memory port: state encoding,
// default word width and the causes that can raise the sticky error flag.
package lc3_pkg;

    localparam int LC3_DATA_W = 16;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RD   = 2'd1;
    localparam logic [1:0] ST_WR   = 2'd2;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_TIMEOUT = 2'd1,
        ERR_COLLIDE = 2'd2,
        ERR_BUSY    = 2'd3
    } err_cause_t;

endpackage

// File: rtl/lc3_mem_port_if.sv
// Controller/memory-side signal bundle for lc3_mem_port; the slave modport
// is the port block itself, the master modport is whoever drives it.
interface lc3_mem_port_if
    import lc3_pkg::*;
#(
    parameter int DATA_W = LC3_DATA_W
) ();

    logic [DATA_W-1:0] bus_in;
    logic              ldMAR;
    logic              ldMDR;
    logic              selMDR;
    logic              memWE;
    logic [DATA_W-1:0] mar;
    logic [DATA_W-1:0] mdr;
    logic              busy;
    logic              done;
    logic              err;
    logic              mem_req;
    logic              mem_we;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output bus_in, ldMAR, ldMDR, selMDR, memWE, mem_ack, mem_rdata,
        input  mar, mdr, busy, done, err, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  bus_in, ldMAR, ldMDR, selMDR, memWE, mem_ack, mem_rdata,
        output mar, mdr, busy, done, err, mem_req, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/lc3_mem_wdog.sv
// Request watchdog: loads TIMEOUT on clear, counts down while enabled and
// flags expiry on the last allowed cycle; saturates at zero.
module lc3_mem_wdog #(
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    logic [TO_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= TO_W'(TIMEOUT);
        end else if (i_enable && (r_count != '0)) begin
            r_count <= r_count - TO_W'(1);
        end
    end

    // Expiring at a count of one gives exactly TIMEOUT request cycles.
    assign o_expire = i_enable && (r_count <= TO_W'(1));

endmodule

// File: rtl/lc3_mem_port.sv
// MAR/MDR holding registers and req/ack memory handshake for the LC3
// controller; busy/done let the controller stall on slow memory.
module lc3_mem_port
    import lc3_pkg::*;
#(
    parameter int DATA_W  = LC3_DATA_W,
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic          clk,
    input  logic          reset,
    lc3_mem_port_if.slave mp
);

    logic [1:0]        r_state;
    logic [DATA_W-1:0] r_mar;
    logic [DATA_W-1:0] r_mdr;
    logic [DATA_W-1:0] r_memAddr;
    logic [DATA_W-1:0] r_memWdata;
    logic              r_memReq;
    logic              r_memWe;
    logic              r_done;
    logic              r_err;

    logic       w_idle;
    logic       w_inFlight;
    logic       w_startWr;
    logic       w_startRd;
    logic       w_loadBus;
    logic       w_ack;
    logic       w_expire;
    logic       w_finish;
    err_cause_t w_errCause;

    assign w_idle     = (r_state == ST_IDLE);
    assign w_inFlight = !w_idle;
    assign w_startWr  = w_idle && mp.memWE;
    assign w_startRd  = w_idle && !mp.memWE && mp.ldMDR && mp.selMDR;
    assign w_loadBus  = w_idle && mp.ldMDR && !mp.selMDR;
    assign w_ack      = w_inFlight && mp.mem_ack;
    assign w_finish   = w_ack || w_expire;

    lc3_mem_wdog #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_wdog (
        .clk      (clk),
        .reset    (reset),
        .i_clear  (w_startWr || w_startRd),
        .i_enable (w_inFlight && !mp.mem_ack),
        .o_expire (w_expire)
    );

    always_comb begin
        w_errCause = ERR_NONE;
        if (w_expire) begin
            w_errCause = ERR_TIMEOUT;
        end else if (w_inFlight && (mp.ldMDR || mp.memWE)) begin
            w_errCause = ERR_BUSY;
        end else if (w_idle && mp.memWE && mp.ldMDR && mp.selMDR) begin
            w_errCause = ERR_COLLIDE;
        end
    end

    // A same-cycle write reads the pre-load MDR because the latch uses r_mdr.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_mar      <= '0;
            r_mdr      <= '0;
            r_memAddr  <= '0;
            r_memWdata <= '0;
            r_memReq   <= 1'b0;
            r_memWe    <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (mp.ldMAR) begin
                r_mar <= mp.bus_in;
            end
            if (w_loadBus) begin
                r_mdr <= mp.bus_in;
            end
            if (w_idle) begin
                if (w_startWr) begin
                    r_state    <= ST_WR;
                    r_memAddr  <= r_mar;
                    r_memWdata <= r_mdr;
                    r_memReq   <= 1'b1;
                    r_memWe    <= 1'b1;
                end else if (w_startRd) begin
                    r_state   <= ST_RD;
                    r_memAddr <= r_mar;
                    r_memReq  <= 1'b1;
                    r_memWe   <= 1'b0;
                end
            end else if (w_finish) begin
                r_state  <= ST_IDLE;
                r_memReq <= 1'b0;
                r_memWe  <= 1'b0;
                r_done   <= 1'b1;
                if (w_ack && (r_state == ST_RD)) begin
                    r_mdr <= mp.mem_rdata;
                end
            end
            if (w_errCause != ERR_NONE) begin
                r_err <= 1'b1;
            end
        end
    end

    assign mp.mar       = r_mar;
    assign mp.mdr       = r_mdr;
    assign mp.busy      = w_inFlight;
    assign mp.done      = r_done;
    assign mp.err       = r_err;
    assign mp.mem_req   = r_memReq;
    assign mp.mem_we    = r_memWe;
    assign mp.mem_addr  = r_memAddr;
    assign mp.mem_wdata = r_memWdata;

endmodule

// File: tb/tb_lc3_mem_port.sv
// Directed bench for lc3_mem_port: a transaction-level model checked every
// cycle, plus literal expectations for each scenario.
module tb_lc3_mem_port;

    localparam int TO = 4;

    logic clk;
    logic reset;

    lc3_mem_port_if #(.DATA_W(16)) mif ();

    lc3_mem_port #(
        .DATA_W  (16),
        .TIMEOUT (TO),
        .TO_W    (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .mp    (mif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checkCount = 0;
    int passCount  = 0;

    // Model: at most one pending transaction, described by kind/address/data/age.
    logic        modelValid = 1'b0;
    logic [15:0] mMar = '0;
    logic [15:0] mMdr = '0;
    logic        mErr = 1'b0;
    logic        mDone = 1'b0;
    logic        pend = 1'b0;
    logic        pendWrite = 1'b0;
    logic [15:0] pendAddr = '0;
    logic [15:0] pendWdata = '0;
    int          waited = 0;

    int          reqCycles = 0;
    int          weCycles = 0;
    int          busyCycles = 0;
    int          doneCount = 0;
    logic [15:0] lastAddr = '0;
    logic [15:0] lastWdata = '0;

    task automatic checkOutput(input string name, input logic [15:0] actual,
                               input logic [15:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    always @(posedge clk) begin
        logic [15:0] nextMar;
        if (reset) begin
            modelValid = 1'b1;
            mMar = '0; mMdr = '0; mErr = 1'b0; mDone = 1'b0;
            pend = 1'b0; pendWrite = 1'b0; pendAddr = '0; pendWdata = '0;
            waited = 0;
        end else begin
            mDone = 1'b0;
            nextMar = mif.ldMAR ? mif.bus_in : mMar;
            if (pend) begin
                if (mif.ldMDR || mif.memWE) mErr = 1'b1;
                if (mif.mem_ack) begin
                    if (!pendWrite) mMdr = mif.mem_rdata;
                    pend = 1'b0;
                    mDone = 1'b1;
                end else begin
                    waited++;
                    if (waited == TO) begin
                        pend = 1'b0;
                        mDone = 1'b1;
                        mErr = 1'b1;
                    end
                end
            end else if (mif.memWE) begin
                pend = 1'b1; pendWrite = 1'b1; waited = 0;
                pendAddr = mMar; pendWdata = mMdr;
                if (mif.ldMDR && mif.selMDR) mErr = 1'b1;
                if (mif.ldMDR && !mif.selMDR) mMdr = mif.bus_in;
            end else if (mif.ldMDR) begin
                if (mif.selMDR) begin
                    pend = 1'b1; pendWrite = 1'b0; waited = 0;
                    pendAddr = mMar;
                end else begin
                    mMdr = mif.bus_in;
                end
            end
            mMar = nextMar;
        end
    end

    always @(negedge clk) begin
        if (modelValid) begin
            checkOutput("mar", mif.mar, mMar);
            checkOutput("mdr", mif.mdr, mMdr);
            checkOutput("busy", 16'(mif.busy), 16'(pend));
            checkOutput("done", 16'(mif.done), 16'(mDone));
            checkOutput("err", 16'(mif.err), 16'(mErr));
            checkOutput("mem_req", 16'(mif.mem_req), 16'(pend));
            if (pend) begin
                checkOutput("mem_we", 16'(mif.mem_we), 16'(pendWrite));
                checkOutput("mem_addr", mif.mem_addr, pendAddr);
                if (pendWrite) checkOutput("mem_wdata", mif.mem_wdata, pendWdata);
            end
        end
        if (mif.mem_req === 1'b1) begin
            reqCycles++;
            lastAddr = mif.mem_addr;
            if (mif.mem_we === 1'b1) begin
                weCycles++;
                lastWdata = mif.mem_wdata;
            end
        end
        if (mif.busy === 1'b1) busyCycles++;
        if (mif.done === 1'b1) doneCount++;
    end

    task automatic applyStimulus(input logic [15:0] bus, input logic ldMar,
                                 input logic ldMdr, input logic sel,
                                 input logic we, input logic ack,
                                 input logic [15:0] rdata);
        mif.bus_in    = bus;
        mif.ldMAR     = ldMar;
        mif.ldMDR     = ldMdr;
        mif.selMDR    = sel;
        mif.memWE     = we;
        mif.mem_ack   = ack;
        mif.mem_rdata = rdata;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus('0, 0, 0, 0, 0, 0, '0);
    endtask

    task automatic applyReset();
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
    endtask

    task automatic clearMonitors();
        reqCycles = 0; weCycles = 0; busyCycles = 0; doneCount = 0;
        lastAddr = '0; lastWdata = '0;
    endtask

    initial begin
        reset = 1'b1;
        mif.bus_in = '0; mif.ldMAR = 0; mif.ldMDR = 0; mif.selMDR = 0;
        mif.memWE = 0; mif.mem_ack = 0; mif.mem_rdata = '0;
        @(posedge clk); #1;
        applyReset();
        checkOutput("rst_mdr", mif.mdr, 16'h0000);
        checkOutput("rst_req", 16'(mif.mem_req), 16'h0000);

        // Read with ack on the third request cycle.
        clearMonitors();
        applyStimulus(16'h3000, 1, 0, 0, 0, 0, '0);
        applyStimulus('0, 0, 1, 1, 0, 0, '0);
        idle(2);
        applyStimulus('0, 0, 0, 0, 0, 1, 16'hBEEF);
        idle(2);
        checkOutput("t1_addr", lastAddr, 16'h3000);
        checkOutput("t1_reqcyc", 16'(reqCycles), 16'd3);
        checkOutput("t1_mdr", mif.mdr, 16'hBEEF);
        checkOutput("t1_done", 16'(doneCount), 16'd1);
        checkOutput("t1_err", 16'(mif.err), 16'd0);

        // Write acknowledged on the first request cycle.
        clearMonitors();
        applyStimulus(16'h1234, 0, 1, 0, 0, 0, '0);
        applyStimulus(16'h4000, 1, 0, 0, 0, 0, '0);
        applyStimulus('0, 0, 0, 0, 1, 0, '0);
        applyStimulus('0, 0, 0, 0, 0, 1, 16'hDEAD);
        idle(2);
        checkOutput("t2_wecyc", 16'(weCycles), 16'd1);
        checkOutput("t2_wdata", lastWdata, 16'h1234);
        checkOutput("t2_addr", lastAddr, 16'h4000);
        checkOutput("t2_busy", 16'(busyCycles), 16'd1);
        checkOutput("t2_mdr", mif.mdr, 16'h1234);

        // Read that never gets an ack.
        clearMonitors();
        applyStimulus('0, 0, 1, 1, 0, 0, '0);
        idle(7);
        checkOutput("t3_reqcyc", 16'(reqCycles), 16'(TO));
        checkOutput("t3_done", 16'(doneCount), 16'd1);
        checkOutput("t3_err", 16'(mif.err), 16'd1);
        checkOutput("t3_mdr", mif.mdr, 16'h1234);
        checkOutput("t3_busy", 16'(mif.busy), 16'd0);

        // Command and MAR load while a read is in flight.
        applyReset();
        clearMonitors();
        applyStimulus(16'h0100, 1, 0, 0, 0, 0, '0);
        applyStimulus('0, 0, 1, 1, 0, 0, '0);
        applyStimulus(16'h5555, 1, 0, 0, 1, 0, '0);
        applyStimulus('0, 0, 0, 0, 0, 1, 16'hCAFE);
        idle(2);
        checkOutput("t4_mar", mif.mar, 16'h5555);
        checkOutput("t4_addr", lastAddr, 16'h0100);
        checkOutput("t4_wecyc", 16'(weCycles), 16'd0);
        checkOutput("t4_err", 16'(mif.err), 16'd1);
        checkOutput("t4_mdr", mif.mdr, 16'hCAFE);

        // Write and read requested in the same cycle.
        applyReset();
        clearMonitors();
        applyStimulus(16'h2222, 1, 0, 0, 0, 0, '0);
        applyStimulus('0, 0, 1, 1, 1, 0, '0);
        applyStimulus('0, 0, 0, 0, 0, 1, 16'h9999);
        idle(2);
        checkOutput("t5_wecyc", 16'(weCycles), 16'd1);
        checkOutput("t5_addr", lastAddr, 16'h2222);
        checkOutput("t5_mdr", mif.mdr, 16'h0000);
        checkOutput("t5_err", 16'(mif.err), 16'd1);

        // Write with a same-cycle direct MDR load, then idle ack.
        applyReset();
        clearMonitors();
        applyStimulus(16'h1111, 0, 1, 0, 0, 0, '0);
        applyStimulus(16'h2222, 0, 1, 0, 1, 0, '0);
        applyStimulus('0, 0, 0, 0, 0, 1, '0);
        applyStimulus('0, 0, 0, 0, 0, 1, 16'hFFFF);
        idle(1);
        checkOutput("t7_wdata", lastWdata, 16'h1111);
        checkOutput("t7_mdr", mif.mdr, 16'h2222);
        checkOutput("t7_done", 16'(doneCount), 16'd1);

        // Reset during a read with an ack pending.
        applyStimulus(16'h7777, 1, 1, 0, 0, 0, '0);
        applyStimulus('0, 0, 1, 1, 0, 0, '0);
        applyStimulus('0, 0, 1, 0, 0, 0, '0);
        reset = 1'b1;
        applyStimulus('0, 0, 0, 0, 0, 1, 16'hABCD);
        checkOutput("t6_req", 16'(mif.mem_req), 16'd0);
        checkOutput("t6_busy", 16'(mif.busy), 16'd0);
        checkOutput("t6_mdr", mif.mdr, 16'h0000);
        checkOutput("t6_err", 16'(mif.err), 16'd0);
        reset = 1'b0;
        idle(2);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
